// File: rtl/clause_loader.sv
// clause_loader: streams literal clauses into a SAT solver, runs the walk and reads back state bytes on SAT.
// Optional walk timeout is enabled by defining CLAUSE_LOADER_TIMEOUT_EN.
module clause_loader #(
    parameter int NUM_BYTES   = 16,
    parameter int MAX_CLAUSES = 256,
    parameter int MAX_WALK    = 65535
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       lit_valid,
    output logic       lit_ready,
    input  logic [7:0] lit_data,
    input  logic       lit_last,
    input  logic       prob_last,
    output logic [7:0] cmd,
    output logic [7:0] bus_a,
    output logic [7:0] bus_b,
    output logic [7:0] bus_c,
    input  logic       sat,
    input  logic       unsat,
    input  logic [7:0] exbus,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic [7:0] out_index,
    output logic       busy,
    output logic       done,
    output logic       result_sat,
    output logic       result_unsat,
    output logic       result_timeout,
    output logic       err_overflow
);

    typedef enum logic [3:0] {
        S_IDLE, S_RST_MODEL, S_RST_STATE, S_LOAD, S_INSERT,
        S_WALK, S_RD_ISSUE, S_RD_WAIT, S_RD_OUT, S_DONE
    } state_t;

    localparam logic [7:0] CMD_NOP       = 8'hFF;
    localparam logic [7:0] CMD_RST_MODEL = 8'h00;
    localparam logic [7:0] CMD_RST_STATE = 8'h01;
    localparam logic [7:0] CMD_INSERT    = 8'h02;
    localparam logic [7:0] CMD_READ      = 8'h03;
    localparam logic [7:0] CMD_WALK      = 8'h04;

    localparam int CW = $clog2(MAX_CLAUSES + 1);
    localparam logic [CW-1:0] CLAUSE_LIMIT = CW'(MAX_CLAUSES);
    localparam logic [7:0]    LAST_INDEX   = 8'(NUM_BYTES - 1);

    state_t        state_q;
    logic [7:0]    cmd_q, bus_a_q, bus_b_q, bus_c_q;
    logic [7:0]    slot_q [3];
    logic [1:0]    lit_cnt_q;
    logic [CW-1:0] clause_cnt_q;
    logic          prob_last_q;
    logic [7:0]    idx_q;
    logic          lit_ready_q, out_valid_q, busy_q, done_q;
    logic [7:0]    out_data_q, out_index_q;
    logic          result_sat_q, result_unsat_q, err_overflow_q;
    logic [7:0]    ins_a, ins_b, ins_c;
    logic          lit_fire;

`ifdef CLAUSE_LOADER_TIMEOUT_EN
    localparam logic [15:0] WALK_LAST = 16'(MAX_WALK - 1);
    logic [15:0] walk_q;
    logic        timeout_q;
    assign result_timeout = timeout_q;
`else
    assign result_timeout = 1'b0;
`endif

    assign lit_fire = lit_valid & lit_ready_q;

    // Short clauses are padded with the literal that closes the clause.
    always_comb begin
        ins_a = slot_q[0];
        ins_b = slot_q[1];
        ins_c = slot_q[2];
        case (lit_cnt_q)
            2'd0: begin
                ins_a = lit_data;
                ins_b = lit_data;
                ins_c = lit_data;
            end
            2'd1: begin
                ins_b = lit_data;
                ins_c = lit_data;
            end
            2'd2: ins_c = lit_data;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            cmd_q          <= CMD_NOP;
            bus_a_q        <= '0;
            bus_b_q        <= '0;
            bus_c_q        <= '0;
            for (int i = 0; i < 3; i++) slot_q[i] <= '0;
            lit_cnt_q      <= '0;
            clause_cnt_q   <= '0;
            prob_last_q    <= 1'b0;
            idx_q          <= '0;
            lit_ready_q    <= 1'b0;
            out_valid_q    <= 1'b0;
            out_data_q     <= '0;
            out_index_q    <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            result_sat_q   <= 1'b0;
            result_unsat_q <= 1'b0;
            err_overflow_q <= 1'b0;
`ifdef CLAUSE_LOADER_TIMEOUT_EN
            walk_q         <= '0;
            timeout_q      <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_q        <= S_RST_MODEL;
                        cmd_q          <= CMD_RST_MODEL;
                        busy_q         <= 1'b1;
                        done_q         <= 1'b0;
                        result_sat_q   <= 1'b0;
                        result_unsat_q <= 1'b0;
                        err_overflow_q <= 1'b0;
                        clause_cnt_q   <= '0;
                        lit_cnt_q      <= '0;
`ifdef CLAUSE_LOADER_TIMEOUT_EN
                        timeout_q      <= 1'b0;
`endif
                    end
                end
                S_RST_MODEL: begin
                    state_q <= S_RST_STATE;
                    cmd_q   <= CMD_RST_STATE;
                end
                S_RST_STATE: begin
                    state_q     <= S_LOAD;
                    cmd_q       <= CMD_NOP;
                    lit_ready_q <= 1'b1;
                end
                S_LOAD: begin
                    if (lit_fire) begin
                        if (lit_last) begin
                            lit_cnt_q <= '0;
                            if (lit_cnt_q == 2'd3) err_overflow_q <= 1'b1;
                            if (clause_cnt_q >= CLAUSE_LIMIT) begin
                                // Clause over the limit: dropped, but the problem still ends on prob_last.
                                err_overflow_q <= 1'b1;
                                if (prob_last) begin
                                    state_q     <= S_WALK;
                                    cmd_q       <= CMD_WALK;
                                    lit_ready_q <= 1'b0;
`ifdef CLAUSE_LOADER_TIMEOUT_EN
                                    walk_q      <= '0;
`endif
                                end
                            end else begin
                                state_q      <= S_INSERT;
                                cmd_q        <= CMD_INSERT;
                                bus_a_q      <= ins_a;
                                bus_b_q      <= ins_b;
                                bus_c_q      <= ins_c;
                                lit_ready_q  <= 1'b0;
                                prob_last_q  <= prob_last;
                                clause_cnt_q <= clause_cnt_q + 1'b1;
                            end
                        end else if (lit_cnt_q == 2'd3) begin
                            err_overflow_q <= 1'b1;
                        end else begin
                            slot_q[lit_cnt_q] <= lit_data;
                            lit_cnt_q         <= lit_cnt_q + 2'd1;
                        end
                    end
                end
                S_INSERT: begin
                    if (prob_last_q) begin
                        state_q <= S_WALK;
                        cmd_q   <= CMD_WALK;
`ifdef CLAUSE_LOADER_TIMEOUT_EN
                        walk_q  <= '0;
`endif
                    end else begin
                        state_q     <= S_LOAD;
                        cmd_q       <= CMD_NOP;
                        lit_ready_q <= 1'b1;
                    end
                end
                S_WALK: begin
                    if (sat) begin
                        result_sat_q <= 1'b1;
                        state_q      <= S_RD_ISSUE;
                        cmd_q        <= CMD_READ;
                        bus_a_q      <= '0;
                        idx_q        <= '0;
                    end else if (unsat) begin
                        result_unsat_q <= 1'b1;
                        state_q        <= S_DONE;
                        cmd_q          <= CMD_NOP;
                        busy_q         <= 1'b0;
                        done_q         <= 1'b1;
                    end
`ifdef CLAUSE_LOADER_TIMEOUT_EN
                    else if (walk_q == WALK_LAST) begin
                        timeout_q <= 1'b1;
                        state_q   <= S_DONE;
                        cmd_q     <= CMD_NOP;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                    end else begin
                        walk_q <= walk_q + 16'd1;
                    end
`endif
                end
                S_RD_ISSUE: begin
                    state_q <= S_RD_WAIT;
                    cmd_q   <= CMD_NOP;
                end
                S_RD_WAIT: begin
                    state_q     <= S_RD_OUT;
                    out_data_q  <= exbus;
                    out_index_q <= idx_q;
                    out_valid_q <= 1'b1;
                end
                S_RD_OUT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        if (idx_q == LAST_INDEX) begin
                            state_q <= S_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_RD_ISSUE;
                            cmd_q   <= CMD_READ;
                            bus_a_q <= idx_q + 8'd1;
                            idx_q   <= idx_q + 8'd1;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    cmd_q   <= CMD_NOP;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign cmd          = cmd_q;
    assign bus_a        = bus_a_q;
    assign bus_b        = bus_b_q;
    assign bus_c        = bus_c_q;
    assign lit_ready    = lit_ready_q;
    assign out_valid    = out_valid_q;
    assign out_data     = out_data_q;
    assign out_index    = out_index_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign result_sat   = result_sat_q;
    assign result_unsat = result_unsat_q;
    assign err_overflow = err_overflow_q;

endmodule

// File: tb/tb_clause_loader.sv
// tb_clause_loader: randomized and directed bench for clause_loader with a clause-level reference model.
// Define CLAUSE_LOADER_TIMEOUT_EN to exercise the walk timeout build.
module tb_clause_loader;

    localparam int NB = 16;
    localparam int MC = 4;
    localparam int MW = 8;
`ifdef CLAUSE_LOADER_TIMEOUT_EN
    localparam int SAT_AFTER = 6;
    localparam int WALK_MAX_RAND = 6;
`else
    localparam int SAT_AFTER = 10;
    localparam int WALK_MAX_RAND = 20;
`endif

    logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic       lit_valid = 1'b0, lit_last = 1'b0, prob_last = 1'b0;
    logic [7:0] lit_data = '0;
    logic       sat = 1'b0, unsat = 1'b0, out_ready = 1'b1;
    logic       lit_ready, out_valid, busy, done;
    logic       result_sat, result_unsat, result_timeout, err_overflow;
    logic [7:0] cmd, bus_a, bus_b, bus_c, exbus, out_data, out_index;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    clause_loader #(.NUM_BYTES(NB), .MAX_CLAUSES(MC), .MAX_WALK(MW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .lit_valid(lit_valid), .lit_ready(lit_ready), .lit_data(lit_data),
        .lit_last(lit_last), .prob_last(prob_last),
        .cmd(cmd), .bus_a(bus_a), .bus_b(bus_b), .bus_c(bus_c),
        .sat(sat), .unsat(unsat), .exbus(exbus),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_index(out_index),
        .busy(busy), .done(done), .result_sat(result_sat), .result_unsat(result_unsat),
        .result_timeout(result_timeout), .err_overflow(err_overflow)
    );

    // Solver read-back model: byte at index i is A0+i, addressed by the last read command.
    logic [7:0] rd_idx = '0;
    always @(negedge clk) if (cmd == 8'h03) rd_idx = bus_a;
    assign exbus = 8'hA0 + rd_idx;

    // Passive monitor and out_ready driver.
    bit          bp_en = 1'b0;
    logic [7:0]  cmd_log[$];
    logic [23:0] ins_log[$];
    logic [7:0]  rd_log[$];
    logic [15:0] out_log[$];
    int          stab_err = 0, ov_seen = 0;
    logic        hold_pend = 1'b0;
    logic [15:0] hold_val = '0;
    always @(negedge clk) begin
        out_ready = bp_en ? ($urandom_range(0, 2) == 0) : 1'b1;
        cmd_log.push_back(cmd);
        if (cmd == 8'h02) ins_log.push_back({bus_a, bus_b, bus_c});
        if (cmd == 8'h03) rd_log.push_back(bus_a);
        if (out_valid) ov_seen++;
        if (hold_pend && (!out_valid || {out_index, out_data} !== hold_val)) stab_err++;
        hold_pend = out_valid && !out_ready;
        hold_val  = {out_index, out_data};
        if (out_valid && out_ready) out_log.push_back({out_index, out_data});
    end

    // Problem description and reference expectations.
    logic [7:0]  lits[$];
    int          lens[$];
    logic [23:0] exp_ins[$];
    bit          exp_ovf;
    int          prob_no = 0;

    function automatic void build_expect();
        int base = 0;
        logic [7:0] a, b, c;
        exp_ins.delete();
        exp_ovf = 1'b0;
        for (int ci = 0; ci < lens.size(); ci++) begin
            int n = lens[ci];
            if (n > 3) exp_ovf = 1'b1;
            if (ci >= MC) exp_ovf = 1'b1;
            else begin
                a = lits[base];
                b = (n >= 2) ? lits[base + 1] : lits[base + n - 1];
                c = (n >= 3) ? lits[base + 2] : lits[base + n - 1];
                exp_ins.push_back({a, b, c});
            end
            base += n;
        end
    endfunction

    task automatic clear_problem();
        lits.delete();
        lens.delete();
    endtask

    task automatic add_clause(input logic [7:0] l0, l1, l2, l3, input int n);
        logic [7:0] v[4];
        v[0] = l0; v[1] = l1; v[2] = l2; v[3] = l3;
        for (int i = 0; i < n; i++) lits.push_back(v[i]);
        lens.push_back(n);
    endtask

    task automatic do_start();
        @(negedge clk);
        cmd_log.delete(); ins_log.delete(); rd_log.delete(); out_log.delete();
        stab_err = 0; ov_seen = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        prob_no++;
        $display("problem %0d: %0d clauses, %0d literals", prob_no, lens.size(), lits.size());
    endtask

    task automatic send_lit(input logic [7:0] d, input logic l, input logic p);
        int t = 0;
        @(negedge clk);
        lit_valid = 1'b1; lit_data = d; lit_last = l; prob_last = p;
        while (!lit_ready && t < 100) begin @(negedge clk); t++; end
        if (t >= 100) begin
            n_checks++;
            $display("FAIL lit_ready_timeout: got lit_ready=0 for 100 cycles, want 1");
        end
        @(posedge clk); #1;
        lit_valid = 1'b0; lit_last = 1'b0; prob_last = 1'b0;
    endtask

    task automatic load_problem();
        int base = 0;
        for (int ci = 0; ci < lens.size(); ci++) begin
            for (int i = 0; i < lens[ci]; i++) begin
                bit last = (i == lens[ci] - 1);
                send_lit(lits[base + i], last, last && (ci == lens.size() - 1));
            end
            base += lens[ci];
        end
    endtask

    task automatic walk_then(input int n, input logic s, input logic u, output int seen);
        int t = 0;
        seen = 0;
        while (seen < n && t < 500) begin
            @(negedge clk);
            if (cmd == 8'h04) seen++;
            t++;
        end
        sat = s; unsat = u;
        @(posedge clk); #1;
        sat = 1'b0; unsat = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        int t = 0;
        while (!done && t < 2000) begin @(negedge clk); t++; end
        ok = done;
    endtask

    function automatic int count_cmd(input logic [7:0] c);
        int n = 0;
        foreach (cmd_log[i]) if (cmd_log[i] == c) n++;
        return n;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++; if (cmd !== 8'hFF) $display("FAIL reset_cmd: got %h want ff", cmd); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else n_pass++;
        n_checks++; if (lit_ready !== 1'b0) $display("FAIL reset_lit_ready: got %b want 0", lit_ready); else n_pass++;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else n_pass++;
        n_checks++; if ({bus_a, bus_b, bus_c} !== 24'h0) $display("FAIL reset_buses: got %h want 000000", {bus_a, bus_b, bus_c}); else n_pass++;
        n_checks++; if ({result_sat, result_unsat, result_timeout, err_overflow} !== 4'b0)
            $display("FAIL reset_status: got %b want 0000", {result_sat, result_unsat, result_timeout, err_overflow}); else n_pass++;
    endtask

    task automatic test_basic();
        int seen; bit ok;
        logic [7:0] seq[$];
        clear_problem();
        add_clause(8'h01, 8'h82, 8'h03, 8'h00, 3);
        do_start(); load_problem(); walk_then(3, 1'b0, 1'b1, seen); wait_done(ok);
        foreach (cmd_log[i]) if (cmd_log[i] != 8'hFF) seq.push_back(cmd_log[i]);
        n_checks++; if (seq.size() < 4 || seq[0] !== 8'h00 || seq[1] !== 8'h01 || seq[2] !== 8'h02 || seq[3] !== 8'h04)
            $display("FAIL basic_cmd_seq: got %p want 0,1,2,4...", seq); else n_pass++;
        n_checks++; if (count_cmd(8'h02) != 1) $display("FAIL basic_insert_cycles: got %0d want 1", count_cmd(8'h02)); else n_pass++;
        n_checks++; if (ins_log.size() != 1 || ins_log[0] !== 24'h018203)
            $display("FAIL basic_insert_buses: got %p want 018203", ins_log); else n_pass++;
        n_checks++; if (!ok || result_unsat !== 1'b1 || result_sat !== 1'b0 || busy !== 1'b0)
            $display("FAIL basic_unsat_done: got done=%b unsat=%b sat=%b busy=%b want 1 1 0 0", done, result_unsat, result_sat, busy); else n_pass++;
        n_checks++; if (rd_log.size() != 0 || err_overflow !== 1'b0)
            $display("FAIL basic_no_read: got reads=%0d ovf=%b want 0 0", rd_log.size(), err_overflow); else n_pass++;
    endtask

    task automatic test_padding();
        int seen; bit ok;
        clear_problem();
        add_clause(8'h05, 8'h00, 8'h00, 8'h00, 1);
        add_clause(8'h06, 8'h87, 8'h00, 8'h00, 2);
        do_start(); load_problem(); walk_then(2, 1'b0, 1'b1, seen); wait_done(ok);
        n_checks++; if (ins_log.size() != 2) $display("FAIL pad_count: got %0d want 2", ins_log.size()); else n_pass++;
        n_checks++; if (ins_log.size() < 1 || ins_log[0] !== 24'h050505) $display("FAIL pad_one_lit: got %p want 050505", ins_log); else n_pass++;
        n_checks++; if (ins_log.size() < 2 || ins_log[1] !== 24'h068787) $display("FAIL pad_two_lit: got %p want 068787", ins_log); else n_pass++;
    endtask

    task automatic test_overflow();
        int seen; bit ok;
        clear_problem();
        add_clause(8'h01, 8'h02, 8'h03, 8'h04, 4);
        do_start(); load_problem(); walk_then(2, 1'b0, 1'b1, seen); wait_done(ok);
        n_checks++; if (ins_log.size() != 1 || ins_log[0] !== 24'h010203) $display("FAIL ovf_insert: got %p want 010203", ins_log); else n_pass++;
        n_checks++; if (err_overflow !== 1'b1 || !ok) $display("FAIL ovf_flag_sticky: got ovf=%b done=%b want 1 1", err_overflow, done); else n_pass++;
        // A clean follow-up problem must clear the sticky flag.
        clear_problem();
        add_clause(8'h09, 8'h0A, 8'h00, 8'h00, 2);
        do_start(); load_problem(); walk_then(1, 1'b0, 1'b1, seen); wait_done(ok);
        n_checks++; if (err_overflow !== 1'b0) $display("FAIL ovf_cleared: got %b want 0", err_overflow); else n_pass++;
    endtask

    task automatic test_clause_limit();
        int seen; bit ok;
        clear_problem();
        for (int i = 0; i < MC + 2; i++) add_clause(8'(8'h20 + i), 8'h00, 8'h00, 8'h00, 1);
        do_start(); load_problem(); walk_then(2, 1'b0, 1'b1, seen); wait_done(ok);
        n_checks++; if (ins_log.size() != MC) $display("FAIL limit_inserts: got %0d want %0d", ins_log.size(), MC); else n_pass++;
        n_checks++; if (err_overflow !== 1'b1) $display("FAIL limit_ovf: got %b want 1", err_overflow); else n_pass++;
        n_checks++; if (!ok || result_unsat !== 1'b1) $display("FAIL limit_walk_reached: got done=%b unsat=%b want 1 1", done, result_unsat); else n_pass++;
    endtask

    task automatic test_random();
        int seen, nw; bit ok;
        for (int it = 0; it < 8; it++) begin
            clear_problem();
            for (int ci = 0; ci < int'($urandom_range(1, MC + 2)); ci++) begin
                int n = $urandom_range(1, 4);
                add_clause(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), n);
            end
            build_expect();
            nw = $urandom_range(1, WALK_MAX_RAND);
            do_start(); load_problem(); walk_then(nw, 1'b0, 1'b1, seen); wait_done(ok);
            n_checks++; if (ins_log.size() != exp_ins.size())
                $display("FAIL rand%0d_insert_count: got %0d want %0d", it, ins_log.size(), exp_ins.size()); else n_pass++;
            for (int i = 0; i < exp_ins.size() && i < ins_log.size(); i++) begin
                n_checks++; if (ins_log[i] !== exp_ins[i])
                    $display("FAIL rand%0d_insert%0d: got %h want %h", it, i, ins_log[i], exp_ins[i]); else n_pass++;
            end
            n_checks++; if (err_overflow !== exp_ovf) $display("FAIL rand%0d_ovf: got %b want %b", it, err_overflow, exp_ovf); else n_pass++;
            n_checks++; if (count_cmd(8'h04) != nw || !ok || result_unsat !== 1'b1)
                $display("FAIL rand%0d_walk: got walk=%0d done=%b unsat=%b want %0d 1 1", it, count_cmd(8'h04), done, result_unsat, nw); else n_pass++;
        end
    endtask

    task automatic test_readback(input bit bp, input logic also_unsat);
        int seen; bit ok;
        clear_problem();
        add_clause(8'h11, 8'h00, 8'h00, 8'h00, 1);
        bp_en = bp;
        do_start(); load_problem(); walk_then(SAT_AFTER, 1'b1, also_unsat, seen); wait_done(ok);
        bp_en = 1'b0;
        n_checks++; if (count_cmd(8'h04) != SAT_AFTER) $display("FAIL rb_walk_cycles: got %0d want %0d", count_cmd(8'h04), SAT_AFTER); else n_pass++;
        n_checks++; if (rd_log.size() != NB) $display("FAIL rb_issue_count: got %0d want %0d", rd_log.size(), NB); else n_pass++;
        for (int i = 0; i < NB && i < rd_log.size(); i++) begin
            n_checks++; if (rd_log[i] !== 8'(i)) $display("FAIL rb_issue%0d: got %h want %h", i, rd_log[i], 8'(i)); else n_pass++;
        end
        n_checks++; if (out_log.size() != NB) $display("FAIL rb_out_count: got %0d want %0d", out_log.size(), NB); else n_pass++;
        for (int i = 0; i < NB && i < out_log.size(); i++) begin
            n_checks++; if (out_log[i] !== {8'(i), 8'(8'hA0 + i)})
                $display("FAIL rb_out%0d: got %h want %h", i, out_log[i], {8'(i), 8'(8'hA0 + i)}); else n_pass++;
        end
        n_checks++; if (stab_err != 0) $display("FAIL rb_hold_stable: got %0d unstable cycles want 0", stab_err); else n_pass++;
        n_checks++; if (!ok || result_sat !== 1'b1 || result_unsat !== 1'b0 || busy !== 1'b0)
            $display("FAIL rb_done: got done=%b sat=%b unsat=%b busy=%b want 1 1 0 0", done, result_sat, result_unsat, busy); else n_pass++;
    endtask

    task automatic test_timeout();
        int seen; bit ok;
        clear_problem();
        add_clause(8'h33, 8'h00, 8'h00, 8'h00, 1);
        do_start(); load_problem();
`ifdef CLAUSE_LOADER_TIMEOUT_EN
        wait_done(ok);
        n_checks++; if (count_cmd(8'h04) != MW) $display("FAIL to_walk_cycles: got %0d want %0d", count_cmd(8'h04), MW); else n_pass++;
        n_checks++; if (!ok || result_timeout !== 1'b1) $display("FAIL to_flag: got done=%b timeout=%b want 1 1", done, result_timeout); else n_pass++;
        n_checks++; if (ov_seen != 0) $display("FAIL to_no_readback: got %0d out_valid cycles want 0", ov_seen); else n_pass++;
`else
        walk_then(30, 1'b0, 1'b0, seen);
        n_checks++; if (seen != 30 || busy !== 1'b1 || done !== 1'b0 || result_timeout !== 1'b0)
            $display("FAIL walk_forever: got walk=%0d busy=%b done=%b timeout=%b want 30 1 0 0", seen, busy, done, result_timeout); else n_pass++;
        walk_then(1, 1'b0, 1'b1, seen); wait_done(ok);
        n_checks++; if (!ok || result_timeout !== 1'b0) $display("FAIL walk_end: got done=%b timeout=%b want 1 0", done, result_timeout); else n_pass++;
`endif
    endtask

    task automatic test_reset_mid();
        int seen;
        clear_problem();
        add_clause(8'h44, 8'h45, 8'h00, 8'h00, 2);
        do_start(); load_problem(); walk_then(3, 1'b0, 1'b0, seen);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++; if (cmd !== 8'hFF || busy !== 1'b0 || bus_a !== 8'h00)
            $display("FAIL mid_reset_async: got cmd=%h busy=%b bus_a=%h want ff 0 00", cmd, busy, bus_a); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        cmd_log.delete();
        repeat (10) @(negedge clk);
        n_checks++; if (count_cmd(8'hFF) != cmd_log.size())
            $display("FAIL mid_reset_quiet: got %0d non-NOP cycles want 0", cmd_log.size() - count_cmd(8'hFF)); else n_pass++;
        n_checks++; if (busy !== 1'b0 || lit_ready !== 1'b0 || done !== 1'b0)
            $display("FAIL mid_reset_idle: got busy=%b lit_ready=%b done=%b want 0 0 0", busy, lit_ready, done); else n_pass++;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_basic();
        test_padding();
        test_overflow();
        test_clause_limit();
        test_random();
        test_readback(1'b1, 1'b0);
        test_readback(1'b0, 1'b1);
        test_timeout();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
